// File: rtl/mic1_shifter.sv
// MIC-1 shifter: combinational pass / sign-keeping shift right 1 / logical shift left 8,
// plus a registered result copy and N/Z flags. Flags are built only with SHIFTER_FLAGS_EN.
module mic1_shifter (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  control,
  input  logic [31:0] data,
  output logic [31:0] dataOut,
  output logic [31:0] dataOutReg,
  output logic        n,
  output logic        z
);

  logic [31:0] w_shift;
  logic [31:0] r_data;

  // Right shift keeps bit 31 in place and zero-fills bit 30; 11 is a reserved bypass.
  always_comb begin
    w_shift = data;
    case (control)
      2'b01:   w_shift = {data[31], 1'b0, data[30:1]};
      2'b10:   w_shift = {data[23:0], 8'h00};
      default: w_shift = data;
    endcase
  end

  assign dataOut = w_shift;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_data <= 32'h0;
    else       r_data <= w_shift;
  end

  assign dataOutReg = r_data;

`ifdef SHIFTER_FLAGS_EN
  logic r_n;
  logic r_z;

  // Z resets high so the flags agree with the cleared result register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_n <= 1'b0;
      r_z <= 1'b1;
    end else begin
      r_n <= w_shift[31];
      r_z <= (w_shift == 32'h0);
    end
  end

  assign n = r_n;
  assign z = r_z;
`else
  assign n = 1'b0;
  assign z = 1'b0;
`endif

endmodule

// File: tb/tb_mic1_shifter.sv
// Directed bench for mic1_shifter; flag expectations follow the SHIFTER_FLAGS_EN build.
module tb_mic1_shifter;

`ifdef SHIFTER_FLAGS_EN
  localparam bit FLAGS = 1'b1;
`else
  localparam bit FLAGS = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic [1:0]  control;
  logic [31:0] data;
  logic [31:0] dataOut;
  logic [31:0] dataOutReg;
  logic        n;
  logic        z;

  int n_chk;
  int n_pass;

  mic1_shifter dut (
    .clk        (clk),
    .reset      (reset),
    .control    (control),
    .data       (data),
    .dataOut    (dataOut),
    .dataOutReg (dataOutReg),
    .n          (n),
    .z          (z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
  endtask

  typedef struct {
    logic [1:0]  ctl;
    logic [31:0] din;
    logic [31:0] dout;
    logic        en;
    logic        ez;
  } vec_t;

  vec_t vecs[$];

  initial begin
    n_chk  = 0;
    n_pass = 0;
    vecs.push_back('{2'b01, 32'h88888888, 32'h84444444, 1'b1, 1'b0});
    vecs.push_back('{2'b10, 32'h88888888, 32'h88888800, 1'b1, 1'b0});
    vecs.push_back('{2'b10, 32'h01000000, 32'h00000000, 1'b0, 1'b1});
    vecs.push_back('{2'b00, 32'h88888888, 32'h88888888, 1'b1, 1'b0});
    vecs.push_back('{2'b11, 32'h88888888, 32'h88888888, 1'b1, 1'b0});
    vecs.push_back('{2'b01, 32'hFFFFFFFF, 32'hBFFFFFFF, 1'b1, 1'b0});
    vecs.push_back('{2'b01, 32'h00000001, 32'h00000000, 1'b0, 1'b1});
    vecs.push_back('{2'b01, 32'h7FFFFFFE, 32'h3FFFFFFF, 1'b0, 1'b0});
    vecs.push_back('{2'b10, 32'h00FFFFFF, 32'hFFFFFF00, 1'b1, 1'b0});
    vecs.push_back('{2'b11, 32'h00000000, 32'h00000000, 1'b0, 1'b1});

    // reset state
    reset   = 1'b1;
    control = 2'b00;
    data    = 32'h0;
    #1;
    chk("rst_dout", dataOut, 32'h0);
    chk("rst_reg",  dataOutReg, 32'h0);
    chk("rst_n",    {31'b0, n}, 32'h0);
    chk("rst_z",    {31'b0, z}, {31'b0, FLAGS});

    // edges during reset must not load; dataOut still combinational
    control = 2'b01;
    data    = 32'h88888888;
    #1;
    chk("rst_comb", dataOut, 32'h84444444);
    @(posedge clk); #1;
    chk("rst_noload", dataOutReg, 32'h0);
    chk("rst_noload_z", {31'b0, z}, {31'b0, FLAGS});

    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("first_load", dataOutReg, 32'h84444444);
    chk("first_n", {31'b0, n}, {31'b0, FLAGS});
    chk("first_z", {31'b0, z}, 32'h0);

    foreach (vecs[i]) begin
      @(negedge clk);
      control = vecs[i].ctl;
      data    = vecs[i].din;
      #1;
      chk($sformatf("v%0d_dout", i), dataOut, vecs[i].dout);
      chk($sformatf("v%0d_hold", i), dataOutReg, (i == 0) ? 32'h84444444 : vecs[i-1].dout);
      @(posedge clk); #1;
      chk($sformatf("v%0d_reg", i), dataOutReg, vecs[i].dout);
      chk($sformatf("v%0d_n", i), {31'b0, n}, {31'b0, FLAGS & vecs[i].en});
      chk($sformatf("v%0d_z", i), {31'b0, z}, {31'b0, FLAGS & vecs[i].ez});
    end

    // asynchronous reset between edges
    @(negedge clk);
    control = 2'b01;
    data    = 32'h88888888;
    @(posedge clk); #1;
    chk("pre_async", dataOutReg, 32'h84444444);
    #2;
    reset = 1'b1;
    #1;
    chk("async_reg", dataOutReg, 32'h0);
    chk("async_n",   {31'b0, n}, 32'h0);
    chk("async_z",   {31'b0, z}, {31'b0, FLAGS});
    data = 32'hFFFFFFFF;
    #1;
    chk("async_comb", dataOut, 32'hBFFFFFFF);

    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_load", dataOutReg, 32'hBFFFFFFF);
    chk("post_rst_n", {31'b0, n}, {31'b0, FLAGS});

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
